rr_cs_arbiter: RTL and testbench
================================

# rr_cs_arbiter

Round-robin arbiter that shares one 8-way chip-select fan-out among 8 requesters. It selects one requester and holds the grant until that requester releases it or a hold timeout expires. It then inserts a guard gap and advances priority. The selected index drives a 3-to-8 active-low decoder, and the decoder output is registered so the chip-select lines are glitch-free.

## Interface
Parameters:
- N_REQ, 8: number of requesters; fixed at 8 (3-bit index)
- HOLD_MAX, 15: maximum cycles a grant may be held before forced release; range 1..255
- GUARD, 1: idle cycles between grants with all selects deasserted; range 0..15

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  global arbitration enable (active-high)
- req  in  8  request per requester, level-sensitive
- done  in  1  release strobe from the currently granted requester
- grant_n  out  8  active-low one-hot chip selects; all-ones when no grant
- gnt_idx  out  3  index of current grant; valid only while gnt_vld=1
- gnt_vld  out  1  a grant is active
- timeout  out  1  one-cycle pulse when a grant is force-released by HOLD_MAX

## Operation
- FSM states: IDLE, GRANT, GUARD.
- Priority pointer ptr[2:0] resets to 0. The search order is ptr, ptr+1, …, ptr+7, mod 8. The first set req bit wins.
- IDLE:
  - If en=1 and |req=1: latch the winner into idx, clear hold_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT: grant_n[idx]=0, gnt_vld=1, gnt_idx=idx. hold_cnt increments each cycle. The grant ends on the first of these:
  - done=1
  - req[idx]=0
  - en=0
  - hold_cnt reaching HOLD_MAX-1 in the current cycle. This is a timeout; timeout pulses in the cycle after that edge.
- On grant end:
  - ptr <= idx+1, with 7 wrapping to 0.
  - If GUARD>0, go to GUARD; otherwise go to IDLE.
- Priority among simultaneous end conditions: done or req drop wins over timeout, so timeout is not pulsed when they coincide.
- GUARD: all grant_n=1, gnt_vld=0. Count GUARD cycles, then go to IDLE. Requests are ignored during GUARD.
- Requests arriving during GRANT are queued implicitly; they are seen at the next IDLE evaluation.
- Only req[idx] dropping affects the current grant. Other req bits changing do not.
- Reset values: state=IDLE, ptr=0, idx=0, hold_cnt=0, grant_n=8'hFF, gnt_idx=0, gnt_vld=0, timeout=0.

## Timing
- All outputs are registered; none has a combinational path from inputs.
- Grant latency: req sampled high at edge k in IDLE, so grant_n is low from edge k+1.
- Release latency: end condition sampled at edge m, so grant_n returns to all-ones from edge m+1.
- Back-to-back with GUARD=0: a new grant can appear at edge m+2. IDLE always takes one evaluation cycle.
- Maximum grant length is HOLD_MAX cycles.
- Minimum gap between two grants is GUARD+1 cycles.
- Reset asserted mid-grant: grant_n goes to all-ones asynchronously, with no wait for clk.
- After rst deasserts, the first grant can occur at the second rising edge.
- timeout is high for exactly one cycle per forced release.

## Structure
- Package rr_cs_pkg holds:
  - the state enum (IDLE, GRANT, GUARD)
  - N_REQ=8 and IDX_W=3
  - the next-index helper function for wrap-around
- Sub-module cs_decoder_38: combinational 3-to-8 active-low decoder with an enable.
  - Inputs: idx and enable = (state==GRANT).
  - Its output is registered into grant_n in the top module.
- The top module contains the FSM, the round-robin search, hold_cnt, guard_cnt and ptr.

## Test plan
- Reset, then req=8'h01 and en=1 → grant_n=8'hFE one cycle later, gnt_idx=0. Pulse done → grant_n=8'hFF next cycle, and ptr=1.
- req=8'hFF held, done pulsed every grant, GUARD=1 → grants in order 0,1,…,7,0 with one cycle of all-ones between grants.
- req=8'h10 held with no done, HOLD_MAX=15 → grant_n=8'hEF for exactly 15 cycles, then a one-cycle timeout pulse, then GUARD, then requester 4 is re-granted.
- done=1 in the same cycle hold_cnt hits HOLD_MAX-1 → release with timeout=0.
- Requester 7 granted and released with req=8'h81 → ptr wraps to 0 and requester 0 is granted next.
- rst asserted mid-GRANT between clock edges → grant_n=8'hFF immediately, and gnt_vld=0.
- Deassert en during GRANT → release at the next edge. No new grant occurs while en=0, even with req=8'hFF.

Source files
------------

// File: rtl/rr_cs_pkg.sv
// Shared types and helpers for the round-robin chip-select arbiter.
package rr_cs_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    // Arbiter phase: searching, holding a grant, or enforcing the idle gap.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // Index of the following requester; 7 wraps to 0 through the natural
    // 3-bit overflow.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return i + {{(IDX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cs_decoder_38.sv
// 3-to-8 active-low decoder with enable; all outputs high when disabled.
module cs_decoder_38
    import rr_cs_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             enable,
    output logic [N_REQ-1:0] sel_n
);

    // Drive exactly one line low for the selected index while enabled.
    always_comb begin
        sel_n = '1;
        if (enable) begin
            sel_n[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/rr_cs_arbiter.sv
// Round-robin arbiter sharing one 8-way active-low chip-select fan-out.
// A grant is held until release, request drop, enable drop or HOLD_MAX
// cycles; a GUARD-cycle idle gap follows and priority moves past the
// last owner. All outputs are registered.
module rr_cs_arbiter
    import rr_cs_pkg::*;
#(
    parameter int unsigned N_REQ    = 8,
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned GUARD    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant_n,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic [7:0]       hold_cnt;
    logic [3:0]       guard_cnt;

    logic [IDX_W-1:0] win_idx;
    logic             win_any;
    logic [IDX_W-1:0] cand;
    logic             hold_hit;
    logic             vol_end;
    logic             grant_end;
    logic [N_REQ-1:0] dec_out;

    // Rotating priority search: first set request starting at ptr.
    always_comb begin
        win_idx = '0;
        win_any = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant end conditions; a voluntary release masks the timeout flag.
    always_comb begin
        hold_hit  = (hold_cnt == 8'(HOLD_MAX - 1));
        vol_end   = done || !req[idx] || !en;
        grant_end = vol_end || hold_hit;
    end

    // Arbitration FSM with hold and guard counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
            guard_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && win_any) begin
                        idx      <= win_idx;
                        hold_cnt <= '0;
                        state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (grant_end) begin
                        timeout   <= hold_hit && !done && req[idx];
                        ptr       <= next_idx(idx);
                        hold_cnt  <= '0;
                        guard_cnt <= '0;
                        state     <= (GUARD != 0) ? S_GUARD : S_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                S_GUARD: begin
                    if (guard_cnt == 4'(GUARD - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    cs_decoder_38 u_dec (
        .idx    (idx),
        .enable (state == S_GRANT),
        .sel_n  (dec_out)
    );

    // Register decoder output and status so chip selects are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_n <= '1;
            gnt_vld <= 1'b0;
            gnt_idx <= '0;
        end else begin
            grant_n <= dec_out;
            gnt_vld <= (state == S_GRANT);
            gnt_idx <= idx;
        end
    end

endmodule

// File: tb/tb_rr_cs_arbiter.sv
// Self-checking bench for rr_cs_arbiter with a cycle-level behavioural model.
module tb_rr_cs_arbiter;

    localparam int HOLD_T  = 15;
    localparam int GUARD_T = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant_n;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner of the bus (-1 none), cycles held, guard cycles left.
    int m_owner, m_held, m_gap, m_ptr, m_idx;
    logic [7:0] exp_gn;
    logic       exp_vld, exp_to;
    logic [2:0] exp_idx;
    logic [7:0] s_req;
    logic       s_en, s_done, s_rst;
    logic       prev_vld = 1'b0;
    int         low_run  = 0;
    int         to_count = 0;
    int         grants[$];
    int         gaps[$];

    rr_cs_arbiter #(.N_REQ(8), .HOLD_MAX(HOLD_T), .GUARD(GUARD_T)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .grant_n (grant_n),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model step at every edge, then compare the DUT just after the edge.
    always @(posedge clk) begin
        s_req = req; s_en = en; s_done = done; s_rst = rst;
        if (s_rst) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0; m_idx = 0;
            exp_gn = 8'hFF; exp_vld = 1'b0; exp_idx = 3'd0; exp_to = 1'b0;
        end else begin
            exp_vld = (m_owner >= 0);
            exp_idx = 3'(m_idx);
            exp_gn  = exp_vld ? ~(8'h01 << m_idx) : 8'hFF;
            exp_to  = 1'b0;
            if (m_owner >= 0) begin
                m_held++;
                if (s_done || !s_req[m_owner[2:0]] || !s_en || m_held == HOLD_T) begin
                    exp_to  = (m_held == HOLD_T) && !s_done && s_req[m_owner[2:0]];
                    m_ptr   = (m_owner + 1) % 8;
                    m_owner = -1;
                    m_gap   = GUARD_T;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (s_en && s_req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (m_owner < 0 && s_req[3'((m_ptr + k) % 8)]) begin
                        m_owner = (m_ptr + k) % 8;
                    end
                end
                m_idx  = m_owner;
                m_held = 0;
            end
        end
        #1;
        chk("grant_n", {24'd0, grant_n}, {24'd0, exp_gn});
        chk("gnt_vld", {31'd0, gnt_vld}, {31'd0, exp_vld});
        chk("timeout", {31'd0, timeout}, {31'd0, exp_to});
        if (exp_vld || s_rst) chk("gnt_idx", {29'd0, gnt_idx}, {29'd0, exp_idx});
        if (timeout) to_count++;
        if (gnt_vld && !prev_vld) begin
            grants.push_back(int'(gnt_idx));
            if (grants.size() > 1) gaps.push_back(low_run);
        end
        low_run  = gnt_vld ? 0 : low_run + 1;
        prev_vld = gnt_vld;
    end

    task automatic wait_vld(input logic v, input int max, input string nm);
        int n = 0;
        while (gnt_vld !== v && n < max) begin
            @(negedge clk);
            n++;
        end
        if (gnt_vld !== v) chk(nm, {31'd0, gnt_vld}, {31'd0, v});
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_vld(1'b0, 10, "release_wait");
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int to0;
        rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;

        // Single request, release, pointer advance.
        do_reset();
        en = 1'b1; req = 8'h01;
        repeat (2) @(negedge clk);
        chk("t1_grant_n", {24'd0, grant_n}, 32'h000000FE);
        chk("t1_idx", {29'd0, gnt_idx}, 32'd0);
        req = 8'h03;
        pulse_done();
        chk("t1_release", {24'd0, grant_n}, 32'h000000FF);
        wait_vld(1'b1, 10, "t1_regrant_wait");
        chk("t1_ptr_moved", {29'd0, gnt_idx}, 32'd1);
        req = 8'h00;
        wait_vld(1'b0, 5, "t1_drop_wait");

        // Full rotation with all requesters active.
        do_reset();
        grants.delete(); gaps.delete();
        en = 1'b1; req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            wait_vld(1'b1, 20, "rr_wait");
            pulse_done();
        end
        req = 8'h00;
        chk("rr_count", grants.size(), 32'd9);
        for (int i = 0; i < 9 && i < grants.size(); i++) chk("rr_order", grants[i], i % 8);
        for (int i = 0; i < gaps.size(); i++) chk("rr_gap", gaps[i], GUARD_T + 1);

        // Forced release after HOLD_MAX cycles, then re-grant.
        do_reset();
        en = 1'b1; req = 8'h10;
        wait_vld(1'b1, 10, "to_wait");
        chk("to_grant_n", {24'd0, grant_n}, 32'h000000EF);
        to0 = to_count;
        cnt = 0;
        while (gnt_vld && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("to_hold_len", cnt, 32'd15);
        chk("to_pulses", to_count - to0, 32'd1);
        wait_vld(1'b1, 10, "to_regrant_wait");
        chk("to_regrant_idx", {29'd0, gnt_idx}, 32'd4);

        // done coincides with the final hold cycle: no timeout pulse.
        do_reset();
        en = 1'b1; req = 8'h10;
        wait_vld(1'b1, 10, "co_wait");
        repeat (13) @(negedge clk);
        chk("co_still_vld", {31'd0, gnt_vld}, 32'd1);
        to0 = to_count;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; req = 8'h00;
        wait_vld(1'b0, 5, "co_rel_wait");
        repeat (3) @(negedge clk);
        chk("co_no_timeout", to_count - to0, 32'd0);

        // Pointer wrap from requester 7 to 0.
        do_reset();
        en = 1'b1; req = 8'h80;
        wait_vld(1'b1, 10, "wr_wait");
        chk("wr_idx7", {29'd0, gnt_idx}, 32'd7);
        req = 8'h81;
        pulse_done();
        wait_vld(1'b1, 10, "wr_wait0");
        chk("wr_idx0", {29'd0, gnt_idx}, 32'd0);
        req = 8'h00;
        wait_vld(1'b0, 5, "wr_drop_wait");

        // Asynchronous reset in the middle of a grant.
        req = 8'h01;
        wait_vld(1'b1, 10, "ar_wait");
        #2 rst = 1'b1;
        #1;
        chk("ar_grant_n", {24'd0, grant_n}, 32'h000000FF);
        chk("ar_vld", {31'd0, gnt_vld}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_edge1_vld", {31'd0, gnt_vld}, 32'd0);
        @(negedge clk);
        chk("ar_edge2_vld", {31'd0, gnt_vld}, 32'd1);
        chk("ar_edge2_gn", {24'd0, grant_n}, 32'h000000FE);

        // Enable dropped mid-grant: release, and no grants while disabled.
        en = 1'b0; req = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        chk("en_release", {31'd0, gnt_vld}, 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt_vld) cnt++;
        end
        chk("en_no_grant", cnt, 32'd0);
        en = 1'b1;
        wait_vld(1'b1, 10, "en_resume_wait");
        chk("en_resume_idx", {29'd0, gnt_idx}, 32'd1);
        req = 8'h00;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
